// File: rtl/bp_stream_lock_arbiter.sv
// bp_stream_lock_arbiter: round-robin arbiter sharing one mem stream port; the grant is held while the winner asserts lock.
// Optional lock-break timeout: define BP_STREAM_ARB_LOCK_TIMEOUT_EN (adds lock_timeout_p and lock_timeout_o).
module bp_stream_lock_arbiter #(
    parameter int num_req_p = 2,
    parameter int header_width_p = 128,
    parameter int data_width_p = 64,
`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
    parameter int lock_timeout_p = 255,
`endif
    localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_req_p*header_width_p-1:0] req_header_i,
    input  logic [num_req_p*data_width_p-1:0]   req_data_i,
    input  logic [num_req_p-1:0]                req_v_i,
    input  logic [num_req_p-1:0]                req_lock_i,
    output logic [num_req_p-1:0]                req_yumi_o,
    output logic [header_width_p-1:0]           mem_header_o,
    output logic [data_width_p-1:0]             mem_data_o,
    output logic                                mem_v_o,
    output logic                                mem_lock_o,
    input  logic                                mem_yumi_i,
    output logic [lg_num_req_lp-1:0]            grant_id_o,
    output logic                                locked_o
`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
    ,
    output logic                                lock_timeout_o
`endif
);

    typedef enum logic {e_arb, e_locked} state_e;

    state_e                    state_r, state_n;
    logic [lg_num_req_lp-1:0]  owner_r, owner_n, rr_ptr_r, rr_ptr_n;
    logic [lg_num_req_lp-1:0]  arb_id, scan_id, sel_id, sel_inc;
    logic                      locked;
    logic [header_width_p-1:0] hdr [num_req_p];
    logic [data_width_p-1:0]   dat [num_req_p];

    for (genvar k = 0; k < num_req_p; k++) begin : g_split
        assign hdr[k] = req_header_i[k*header_width_p +: header_width_p];
        assign dat[k] = req_data_i[k*data_width_p +: data_width_p];
    end

    // Scan downward so the lowest offset from rr_ptr_r wins; modulo keeps non-power-of-two counts in range.
    always_comb begin
        arb_id = '0;
        scan_id = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            scan_id = lg_num_req_lp'((int'(rr_ptr_r) + i) % num_req_p);
            if (req_v_i[scan_id])
                arb_id = scan_id;
        end
    end

    always_comb begin
        locked = state_r == e_locked;
        sel_id = locked ? owner_r : arb_id;
        sel_inc = (sel_id == lg_num_req_lp'(num_req_p - 1)) ? '0 : sel_id + lg_num_req_lp'(1);
        mem_v_o = locked ? req_v_i[owner_r] : |req_v_i;
        mem_header_o = mem_v_o ? hdr[sel_id] : '0;
        mem_data_o = mem_v_o ? dat[sel_id] : '0;
        mem_lock_o = mem_v_o & req_lock_i[sel_id];
        req_yumi_o = mem_yumi_i ? (num_req_p'(1) << sel_id) : '0;
        grant_id_o = sel_id;
        locked_o = locked;
    end

`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
    logic [15:0] idle_cnt_r;
    logic        owner_idle, timeout_hit;

    assign owner_idle = locked & ~req_v_i[owner_r];
    assign timeout_hit = owner_idle && (idle_cnt_r + 16'd1 == 16'(lock_timeout_p));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idle_cnt_r <= '0;
            lock_timeout_o <= 1'b0;
        end else begin
            idle_cnt_r <= (owner_idle && !timeout_hit) ? idle_cnt_r + 16'd1 : '0;
            lock_timeout_o <= timeout_hit;
        end
    end
`endif

    // The pointer only moves on a message's final (unlocked) beat, giving message-level fairness.
    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        rr_ptr_n = rr_ptr_r;
        if (mem_yumi_i && mem_lock_o) begin
            state_n = e_locked;
            owner_n = sel_id;
        end else if (mem_yumi_i) begin
            state_n = e_arb;
            rr_ptr_n = sel_inc;
        end
`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
        else if (timeout_hit) begin
            state_n = e_arb;
            rr_ptr_n = sel_inc;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_arb;
            owner_r <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            rr_ptr_r <= rr_ptr_n;
        end
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) mem_yumi_i |-> mem_v_o);

endmodule

// File: tb/tb_bp_stream_lock_arbiter.sv
// tb_bp_stream_lock_arbiter: directed and randomized checks of bp_stream_lock_arbiter against a message-level model.
module tb_bp_stream_lock_arbiter;
    localparam int N = 3;
    localparam int H = 32;
    localparam int D = 16;
`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
    localparam int TP = 4;
    localparam int BUB = TP - 1;
`else
    localparam int BUB = 5;
`endif

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [N*H-1:0] req_header_i;
    logic [N*D-1:0] req_data_i;
    logic [N-1:0]   req_v_i, req_lock_i, req_yumi_o;
    logic [H-1:0]   mem_header_o;
    logic [D-1:0]   mem_data_o;
    logic           mem_v_o, mem_lock_o, mem_yumi_i, locked_o;
    logic [1:0]     grant_id_o;
`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
    logic           lock_timeout_o;
`endif

    always #5 clk_i = ~clk_i;

    bp_stream_lock_arbiter #(
        .num_req_p(N), .header_width_p(H), .data_width_p(D)
`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
        , .lock_timeout_p(TP)
`endif
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_header_i(req_header_i), .req_data_i(req_data_i),
        .req_v_i(req_v_i), .req_lock_i(req_lock_i), .req_yumi_o(req_yumi_o),
        .mem_header_o(mem_header_o), .mem_data_o(mem_data_o),
        .mem_v_o(mem_v_o), .mem_lock_o(mem_lock_o), .mem_yumi_i(mem_yumi_i),
        .grant_id_o(grant_id_o), .locked_o(locked_o)
`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
        , .lock_timeout_o(lock_timeout_o)
`endif
    );

    int checks = 0;
    int passes = 0;

    // Message-level model: who holds the port, and whose turn comes next.
    int m_locked, m_owner, m_ptr, m_silent;
    bit m_pulse;
    int e_sel;
    bit e_v, e_lock;
    logic [H-1:0] e_hdr;
    logic [D-1:0] e_dat;

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_silent = 0; m_pulse = 0;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] lock, input logic y);
        req_header_i = {$urandom, $urandom, $urandom};
        req_data_i = (N*D)'({$urandom, $urandom});
        req_v_i = v;
        req_lock_i = lock;
        e_sel = -1;
        if (m_locked != 0) begin
            e_sel = m_owner;
            e_v = v[m_owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                int j = (m_ptr + k) % N;
                if (v[j]) begin
                    e_sel = j;
                    break;
                end
            end
            e_v = e_sel >= 0;
        end
        e_hdr = '0; e_dat = '0; e_lock = 0;
        if (e_v) begin
            e_hdr = req_header_i[e_sel*H +: H];
            e_dat = req_data_i[e_sel*D +: D];
            e_lock = lock[e_sel];
        end
        mem_yumi_i = y && e_v;
        #1;
    endtask

    task automatic advance();
`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
        m_pulse = 0;
        if (m_locked != 0 && !req_v_i[m_owner]) begin
            m_silent++;
            if (m_silent == TP) begin
                m_locked = 0; m_ptr = (m_owner + 1) % N; m_silent = 0; m_pulse = 1;
            end
        end else m_silent = 0;
`endif
        if (mem_yumi_i) begin
            if (e_lock) begin m_locked = 1; m_owner = e_sel; end
            else begin m_locked = 0; m_ptr = (e_sel + 1) % N; end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; req_v_i = '0; req_lock_i = '0; mem_yumi_i = 1'b0;
        req_header_i = '0; req_data_i = '0;
        #3;
        checks++; if (mem_v_o !== 1'b0) $display("FAIL reset_mem_v got %b expected 0", mem_v_o); else passes++;
        checks++; if (req_yumi_o !== 3'b000) $display("FAIL reset_yumi got %b expected 000", req_yumi_o); else passes++;
        checks++; if (locked_o !== 1'b0) $display("FAIL reset_locked got %b expected 0", locked_o); else passes++;
        checks++; if (grant_id_o !== 2'd0) $display("FAIL reset_grant got %0d expected 0", grant_id_o); else passes++;
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) begin
            drive(3'b011, 3'b000, 1'b1);
            checks++; if (grant_id_o !== 2'(i % 2)) $display("FAIL rr_grant beat %0d got %0d expected %0d", i, grant_id_o, i % 2); else passes++;
            checks++; if (req_yumi_o !== ((i % 2) ? 3'b010 : 3'b001)) $display("FAIL rr_yumi beat %0d got %b expected %b", i, req_yumi_o, (i % 2) ? 3'b010 : 3'b001); else passes++;
            checks++; if (mem_header_o !== req_header_i[(i%2)*H +: H]) $display("FAIL rr_header beat %0d got %h expected %h", i, mem_header_o, req_header_i[(i%2)*H +: H]); else passes++;
            advance();
        end
    endtask

    task automatic test_locked_msg();
        logic [3:0] lk;
        lk = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            drive(3'b011, {2'b00, lk[i]}, 1'b1);
            checks++; if (grant_id_o !== 2'd0) $display("FAIL lock_grant beat %0d got %0d expected 0", i, grant_id_o); else passes++;
            checks++; if (locked_o !== (i > 0)) $display("FAIL lock_state beat %0d got %b expected %b", i, locked_o, i > 0); else passes++;
            checks++; if (mem_lock_o !== lk[i]) $display("FAIL lock_pass beat %0d got %b expected %b", i, mem_lock_o, lk[i]); else passes++;
            advance();
        end
        drive(3'b011, 3'b000, 1'b1);
        checks++; if (grant_id_o !== 2'd1) $display("FAIL lock_next_grant got %0d expected 1", grant_id_o); else passes++;
        checks++; if (req_yumi_o !== 3'b010) $display("FAIL lock_next_yumi got %b expected 010", req_yumi_o); else passes++;
        advance();
    endtask

    task automatic test_backpressure();
        drive(3'b011, 3'b001, 1'b1);
        checks++; if (grant_id_o !== 2'd0) $display("FAIL bp_first_grant got %0d expected 0", grant_id_o); else passes++;
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(3'b011, 3'b001, 1'b0);
            checks++; if (mem_v_o !== 1'b1) $display("FAIL bp_stall_v cycle %0d got %b expected 1", i, mem_v_o); else passes++;
            checks++; if (grant_id_o !== 2'd0) $display("FAIL bp_stall_grant cycle %0d got %0d expected 0", i, grant_id_o); else passes++;
            checks++; if (req_yumi_o !== 3'b000) $display("FAIL bp_stall_yumi cycle %0d got %b expected 000", i, req_yumi_o); else passes++;
            advance();
        end
        drive(3'b011, 3'b000, 1'b1);
        checks++; if (req_yumi_o !== 3'b001) $display("FAIL bp_final_yumi got %b expected 001", req_yumi_o); else passes++;
        checks++; if (locked_o !== 1'b1) $display("FAIL bp_final_locked got %b expected 1", locked_o); else passes++;
        advance();
    endtask

    task automatic test_owner_bubble();
        drive(3'b011, 3'b000, 1'b1);
        checks++; if (grant_id_o !== 2'd1) $display("FAIL bub_pre_grant got %0d expected 1", grant_id_o); else passes++;
        advance();
        drive(3'b011, 3'b001, 1'b1);
        checks++; if (grant_id_o !== 2'd0) $display("FAIL bub_lock_grant got %0d expected 0", grant_id_o); else passes++;
        advance();
        for (int i = 0; i < BUB; i++) begin
            drive(3'b010, 3'b000, 1'b1);
            checks++; if (mem_v_o !== 1'b0) $display("FAIL bub_v cycle %0d got %b expected 0", i, mem_v_o); else passes++;
            checks++; if (req_yumi_o !== 3'b000) $display("FAIL bub_yumi cycle %0d got %b expected 000", i, req_yumi_o); else passes++;
            checks++; if (grant_id_o !== 2'd0) $display("FAIL bub_grant cycle %0d got %0d expected 0", i, grant_id_o); else passes++;
            checks++; if (mem_header_o !== '0) $display("FAIL bub_header cycle %0d got %h expected 0", i, mem_header_o); else passes++;
            advance();
        end
        drive(3'b011, 3'b000, 1'b1);
        checks++; if (mem_v_o !== 1'b1 || grant_id_o !== 2'd0) $display("FAIL bub_resume got v=%b id=%0d expected v=1 id=0", mem_v_o, grant_id_o); else passes++;
        checks++; if (mem_data_o !== req_data_i[D-1:0]) $display("FAIL bub_resume_data got %h expected %h", mem_data_o, req_data_i[D-1:0]); else passes++;
        advance();
    endtask

    task automatic test_wrap();
        drive(3'b010, 3'b000, 1'b1);
        checks++; if (grant_id_o !== 2'd1) $display("FAIL wrap_pre_grant got %0d expected 1", grant_id_o); else passes++;
        advance();
        drive(3'b011, 3'b000, 1'b1);
        checks++; if (grant_id_o !== 2'd0) $display("FAIL wrap_grant got %0d expected 0", grant_id_o); else passes++;
        advance();
        drive(3'b011, 3'b000, 1'b0);
        checks++; if (grant_id_o !== 2'd1) $display("FAIL wrap_ptr got %0d expected 1", grant_id_o); else passes++;
        advance();
    endtask

    task automatic test_async_reset();
        drive(3'b010, 3'b000, 1'b1);
        advance();
        drive(3'b100, 3'b100, 1'b1);
        checks++; if (grant_id_o !== 2'd2) $display("FAIL ar_lock_grant got %0d expected 2", grant_id_o); else passes++;
        advance();
        req_v_i = 3'b111; req_lock_i = 3'b000; mem_yumi_i = 1'b0;
        #1;
        checks++; if (locked_o !== 1'b1 || grant_id_o !== 2'd2) $display("FAIL ar_held got locked=%b id=%0d expected locked=1 id=2", locked_o, grant_id_o); else passes++;
        reset_i = 1'b1;
        #1;
        checks++; if (locked_o !== 1'b0) $display("FAIL ar_locked got %b expected 0", locked_o); else passes++;
        checks++; if (grant_id_o !== 2'd0) $display("FAIL ar_ptr got %0d expected 0", grant_id_o); else passes++;
        checks++; if (req_yumi_o !== 3'b000) $display("FAIL ar_yumi got %b expected 000", req_yumi_o); else passes++;
        @(posedge clk_i); #1;
        req_v_i = '0;
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_yumi;
        for (int c = 0; c < 400; c++) begin
            drive(3'($urandom), 3'($urandom | $urandom), ($urandom % 4) != 0);
            exp_yumi = mem_yumi_i ? 3'(1 << e_sel) : 3'b000;
            checks++; if (mem_v_o !== e_v) $display("FAIL rnd_v cycle %0d got %b expected %b", c, mem_v_o, e_v); else passes++;
            checks++; if (req_yumi_o !== exp_yumi) $display("FAIL rnd_yumi cycle %0d got %b expected %b", c, req_yumi_o, exp_yumi); else passes++;
            checks++; if (mem_header_o !== e_hdr || mem_data_o !== e_dat) $display("FAIL rnd_payload cycle %0d got %h/%h expected %h/%h", c, mem_header_o, mem_data_o, e_hdr, e_dat); else passes++;
            checks++; if (mem_lock_o !== e_lock) $display("FAIL rnd_lock cycle %0d got %b expected %b", c, mem_lock_o, e_lock); else passes++;
            checks++; if (locked_o !== (m_locked != 0)) $display("FAIL rnd_locked cycle %0d got %b expected %0d", c, locked_o, m_locked); else passes++;
            if (e_v || m_locked != 0) begin
                checks++; if (grant_id_o !== 2'(e_sel)) $display("FAIL rnd_grant cycle %0d got %0d expected %0d", c, grant_id_o, e_sel); else passes++;
            end
`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
            checks++; if (lock_timeout_o !== m_pulse) $display("FAIL rnd_timeout cycle %0d got %b expected %b", c, lock_timeout_o, m_pulse); else passes++;
`endif
            advance();
        end
    endtask

`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
    task automatic test_timeout();
        if (m_locked != 0) begin
            drive(3'b111, 3'b000, 1'b1);
            advance();
        end
        drive(3'b001, 3'b001, 1'b1);
        advance();
        for (int i = 0; i < TP; i++) begin
            drive(3'b000, 3'b000, 1'b0);
            checks++; if (lock_timeout_o !== 1'b0 || locked_o !== 1'b1) $display("FAIL to_wait cycle %0d got pulse=%b locked=%b expected 0/1", i, lock_timeout_o, locked_o); else passes++;
            advance();
        end
        checks++; if (lock_timeout_o !== 1'b1) $display("FAIL to_pulse got %b expected 1", lock_timeout_o); else passes++;
        checks++; if (locked_o !== 1'b0) $display("FAIL to_unlock got %b expected 0", locked_o); else passes++;
        drive(3'b110, 3'b000, 1'b0);
        checks++; if (grant_id_o !== 2'd1) $display("FAIL to_ptr got %0d expected 1", grant_id_o); else passes++;
        advance();
        checks++; if (lock_timeout_o !== 1'b0) $display("FAIL to_pulse_end got %b expected 0", lock_timeout_o); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_locked_msg();
        test_backpressure();
        test_owner_bubble();
        test_wrap();
        test_async_reset();
        test_random();
`ifdef BP_STREAM_ARB_LOCK_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/bp_stream_lock_arbiter.md
Name: bp_stream_lock_arbiter

Overview:
- Round-robin arbiter that shares one outbound BedRock memory stream port between num_req_p stream-pump producers.
- Each producer presents header, data, valid and lock. The arbiter grants one producer at a time.
- The grant is held for as long as the winner asserts lock, so a multi-beat message (header plus N data beats) is never interleaved with another producer's beats.
- Sits between several stream-pump-out instances (e.g. I/O and memory paths) and the single downstream network or memory link.

Parameters:
- num_req_p, 2, number of requesters; legal range 2..8.
- header_width_p, 128, width of each BedRock mem header.
- data_width_p, 64, stream data beat width.
- lg_num_req_lp, `BSG_SAFE_CLOG2(num_req_p), localparam, grant index width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- req_header_i  in  num_req_p*header_width_p  per-requester headers; requester k occupies slice k.
- req_data_i  in  num_req_p*data_width_p  per-requester data.
- req_v_i  in  num_req_p  per-requester valid.
- req_lock_i  in  num_req_p  per-requester lock (more beats of this message follow).
- req_yumi_o  out  num_req_p  one-hot-or-zero dequeue to requesters.
- mem_header_o  out  header_width_p  selected header.
- mem_data_o  out  data_width_p  selected data.
- mem_v_o  out  1  selected valid.
- mem_lock_o  out  1  selected lock, passed through.
- mem_yumi_i  in  1  downstream consumed the current beat.
- grant_id_o  out  lg_num_req_lp  index currently selected; meaningful when mem_v_o=1 or locked_o=1.
- locked_o  out  1  arbiter is in e_locked.

Behaviour:
- The select path is combinational: mem_* outputs are a mux of the requester at sel_id. When nothing is selected, mem_v_o=0 and header, data and lock are 0.
- Two-state FSM: e_arb and e_locked. Registers are state_r, owner_r and rr_ptr_r.
- Reset: state_r=e_arb, rr_ptr_r=0, owner_r=0. While in reset and with no valids, mem_v_o=0, req_yumi_o=0, locked_o=0 and grant_id_o=0.
- e_arb:
  - sel_id = first index with req_v_i set, searching from rr_ptr_r upward with wrap-around.
  - mem_v_o = |req_v_i.
  - The arbitration decision may change cycle to cycle until consumed; a valid with no yumi is not a commitment.
- e_locked:
  - sel_id = owner_r and mem_v_o = req_v_i[owner_r].
  - All other requesters are ignored, even if valid.
  - If the owner drops valid, wait indefinitely, except under the optional feature below.
- req_yumi_o[sel_id] = mem_yumi_i; all other bits are 0. mem_yumi_i while mem_v_o=0 is illegal and is checked by an assertion.
- Transitions on mem_yumi_i:
  - Consumed beat with mem_lock_o=1: go to (or stay in) e_locked, owner_r <= sel_id.
  - Consumed beat with mem_lock_o=0: go to e_arb, rr_ptr_r <= sel_id+1 mod num_req_p.
- Fairness: a single-beat message and a locked message both move the pointer only on their final beat. This gives round-robin at message granularity, not beat granularity.
- rr_ptr_r wraps from num_req_p-1 to 0. When num_req_p is not a power of two, the modulo is explicit.
- Asynchronous reset asserted mid-message returns the FSM to e_arb immediately. The partial message is dropped; requesters are reset together with the arbiter.
- Latency: zero-cycle combinational pass-through. There is no buffering.

Optional Feature:
- Macro: BP_STREAM_ARB_LOCK_TIMEOUT_EN.
- When defined:
  - Adds parameter lock_timeout_p (default 255).
  - Adds output port lock_timeout_o (1 bit).
  - An 8..16-bit counter increments each cycle in e_locked while req_v_i[owner_r]=0, and clears on any owner valid or on leaving e_locked.
  - When the counter reaches lock_timeout_p, lock_timeout_o pulses for one cycle, the FSM is forced to e_arb, and rr_ptr_r <= owner_r+1. This breaks the lock.
  - The counter resets to 0.
- When undefined: no counter and no port; the lock is held indefinitely.

Test Plan:
- Single beats from both requesters: req_v_i=2'b11, lock=0, yumi every cycle -> grants alternate 0,1,0,1. req_yumi_o is 01,10,01,10.
- Locked message: req0 sends 4 beats with lock=1,1,1,0 while req1 is valid throughout -> grant_id_o=0 for 4 consumed beats and locked_o=1 after the first beat. req1 is granted on the 5th cycle.
- Backpressure: req0 locked, mem_yumi_i=0 for 3 cycles then 1 -> mem_v_o stays 1, owner unchanged, no yumi pulses during the stall.
- Owner bubble: in e_locked req0 drops valid for 5 cycles while req1 is valid -> mem_v_o=0, req_yumi_o=0, grant_id_o=0. When req0 reasserts, its beat is forwarded.
- Wrap with num_req_p=3: rr_ptr_r=2, valids 3'b011 -> req0 granted; after its final beat rr_ptr_r=1.
- Async reset pulsed mid-lock -> locked_o=0 and rr_ptr_r=0 immediately without a clock edge. With BP_STREAM_ARB_LOCK_TIMEOUT_EN and lock_timeout_p=4, an owner silent for 4 cycles -> lock_timeout_o pulse and the FSM is in e_arb.
